// File: rtl/fifo_mul_consumer_pkg.sv
// rtl/fifo_mul_consumer_pkg.sv - shared types and default widths for the FIFO multiply consumer
//
// Purpose: FSM state encoding and default width constants shared by the
//          multiply consumer and anything that instantiates it.
// Contents: mul_state_t, MUL_DATA_LEN, MUL_OP_LEN.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} mul_state_t;

  localparam int MUL_DATA_LEN = 16;
  localparam int MUL_OP_LEN   = 8;

endpackage

// File: rtl/fifo_mul_consumer.sv
// rtl/fifo_mul_consumer.sv - FIFO read-side consumer with shift-add multiplier
//
// Purpose: pops one packed {a, b} word from the operand FIFO, multiplies
//          a*b (unsigned) with a fixed-latency radix-2 shift-add loop and
//          offers the product on a valid/ready port.
// Ports:
//   clk        in   FIFO read clock
//   reset_n    in   asynchronous active-low reset
//   fifo_data  in   FIFO read data, a = upper half, b = lower half
//   fifo_empty in   FIFO empty flag
//   fifo_rd_en out  pop request (only ever asserted in IDLE)
//   out_data   out  registered product
//   out_valid  out  product available
//   out_ready  in   downstream accepts product
//   busy       out  FSM is not in IDLE
module fifo_mul_consumer
  import mul_pkg::*;
#(
  parameter int DATA_LEN = MUL_DATA_LEN,
  parameter int OP_LEN   = DATA_LEN / 2,
  parameter int PROD_LEN = 2 * OP_LEN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_LEN-1:0] fifo_data,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [PROD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int CNT_W = $clog2(OP_LEN + 1);

  mul_state_t          r_state;
  logic [PROD_LEN-1:0] r_acc;
  logic [PROD_LEN-1:0] r_mcand;
  logic [OP_LEN-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic [PROD_LEN-1:0] r_out_data;

  logic [PROD_LEN-1:0] w_acc_next;
  logic                w_last_step;

  // One partial-product step; the final sum fits in PROD_LEN bits.
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_step = (r_cnt == CNT_W'(1));

  // Gated by reset_n so no pop is requested while reset is held.
  assign fifo_rd_en = reset_n && (r_state == IDLE) && !fifo_empty;
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign out_data   = r_out_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // FIFO read data is registered, so it is valid one cycle after the pop.
          r_mcand  <= {{(PROD_LEN - OP_LEN){1'b0}}, fifo_data[DATA_LEN-1:OP_LEN]};
          r_mplier <= fifo_data[OP_LEN-1:0];
          r_acc    <= '0;
          r_cnt    <= CNT_W'(OP_LEN);
          r_state  <= MUL;
        end
        MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          // Always runs OP_LEN steps; the result register only changes here,
          // so out_data holds steady through DONE and back-pressure.
          if (w_last_step) begin
            r_out_data <= w_acc_next;
            r_state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mul_consumer.sv
// tb/tb_fifo_mul_consumer.sv - self-checking bench for fifo_mul_consumer
module tb_fifo_mul_consumer;

  localparam int LAT  = 9;   // posedges from the pop edge to the edge that enters DONE
  localparam int GAP  = 11;  // cycles between products with out_ready high

  typedef struct {
    logic [15:0] word;
    logic [15:0] prod;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int got   = 0;
  int pop_cyc = 0;
  int hs_cyc  = 0;
  int last_rise = 0;
  bit rd_sampled = 0;
  bit prev_v = 0;
  bit prev_r = 0;
  bit spacing_en = 0;
  bit have_rise = 0;
  logic [15:0] prev_d = '0;
  logic [15:0] last_prod = '0;
  logic [15:0] fq[$];
  logic [15:0] exp_q[$];

  fifo_mul_consumer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_got(input int target, input string name);
    int n = 0;
    while (got < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, got, target);
  endtask

  // FIFO model with registered read data; expected product queued at pop time.
  always @(posedge clk) begin
    logic [15:0] w;
    logic [15:0] p;
    cyc++;
    if (rd_sampled && fq.size() > 0) begin
      pops++;
      pop_cyc = cyc;
      w = fq.pop_front();
      p = 16'(w[15:8]) * 16'(w[7:0]);
      exp_q.push_back(p);
      #1;
      fifo_data  = w;
      fifo_empty = (fq.size() == 0);
    end
  end

  // Monitor: samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    rd_sampled = fifo_rd_en;
    if (!reset_n) begin
      prev_v = 0;
      prev_r = 0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && !prev_v) begin
        chk("latency", cyc - pop_cyc, LAT);
        if (spacing_en && have_rise) chk("spacing", cyc - last_rise, GAP);
        last_rise = cyc;
        have_rise = 1;
      end
      if (out_valid) chk("rd_en_in_done", fifo_rd_en, 0);
      if (out_valid && out_ready) begin
        hs_cyc    = cyc + 1;
        last_prod = out_data;
        got++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_product: got %0h want none", out_data);
        end else begin
          chk("product", out_data, exp_q.pop_front());
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end
  end

  initial begin
    vec_t tab[5];
    int   p0;
    int   g0;
    int   hs1;
    int   n;

    tab[0] = '{16'h0D0B, 16'h008F};
    tab[1] = '{16'hFFFF, 16'hFE01};
    tab[2] = '{16'h00A5, 16'h0000};
    tab[3] = '{16'h8001, 16'h0080};
    tab[4] = '{16'h0101, 16'h0001};

    reset_n    = 1'b0;
    fifo_data  = '0;
    fifo_empty = 1'b1;
    out_ready  = 1'b1;

    // Reset held with a word waiting.
    repeat (2) @(negedge clk);
    push(tab[0].word);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("first_idle_rd_en", fifo_rd_en, 1);

    // Table-driven products.
    for (int i = 0; i < 5; i++) begin
      p0 = pops;
      if (i > 0) push(tab[i].word);
      wait_got(got + 1, $sformatf("wait_vec%0d", i));
      chk($sformatf("vec%0d_prod", i), last_prod, tab[i].prod);
      chk($sformatf("vec%0d_pops", i), pops - p0, 1);
    end

    // Back-pressure with a second word waiting.
    out_ready = 1'b0;
    g0 = got;
    push(16'h0302);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    push(16'h0404);
    p0 = pops;
    repeat (5) @(negedge clk);
    chk("bp_no_pop", pops - p0, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 16'h0006);
    out_ready = 1'b1;
    wait_got(g0 + 1, "bp_wait1");
    chk("bp_first", last_prod, 16'h0006);
    hs1 = hs_cyc;
    wait_got(g0 + 2, "bp_wait2");
    chk("bp_second", last_prod, 16'h0010);
    chk("bp_pop_after_hs", pop_cyc - hs1, 1);

    // Back-to-back stream.
    @(negedge clk);
    spacing_en = 1;
    have_rise  = 0;
    g0 = got;
    push(16'h0102);
    push(16'h0304);
    push(16'h0506);
    push(16'h0708);
    wait_got(g0 + 4, "stream_wait");
    chk("stream_last", last_prod, 16'h0038);
    spacing_en = 0;

    // Reset in the middle of MUL.
    @(negedge clk);
    p0 = pops;
    push(16'h1010);
    n = 0;
    while (pops == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pop", pops - p0, 1);
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_hold_valid", out_valid, 0);
    reset_n = 1'b1;
    g0 = got;
    push(16'h0203);
    wait_got(g0 + 1, "post_rst_wait");
    chk("post_rst_prod", last_prod, 16'h0006);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
